axicb_wr_arbiter: RTL and testbench
===================================

// Module: axicb_wr_arbiter
// PURPOSE
//  Write-path arbiter for one crossbar slave port. Shares the port between MST_NB master interfaces.
//  - AW: round-robin arbitration.
//  - W: beats are routed in the order AWs were granted.
//  - Outstanding writes are capped at OSTD_NUM; completions are counted from the slave-side B handshake.
//  - Sits between the per-master slave-interface buffers and the slave-side switch.
// PARAMETERS
//  MST_NB    4  number of requesting masters (2..16)
//  AWCH_W    8  packed AW channel width
//  WCH_W     8  packed W channel width (excludes wlast)
//  OSTD_NUM  4  max AWs granted without B completion (1..64); also the order-queue depth
// PORTS
//  aclk         in   1              clock
//  aresetn      in   1              async active-low reset
//  srst         in   1              sync active-high clear, same effect as reset
//  i_awvalid    in   MST_NB         per-master AW valid
//  i_awready    out  MST_NB         per-master AW ready
//  i_awch       in   MST_NB*AWCH_W  per-master AW payload, master m at [m*AWCH_W +: AWCH_W]
//  i_wvalid     in   MST_NB         per-master W valid
//  i_wready     out  MST_NB         per-master W ready
//  i_wlast      in   MST_NB         per-master W last
//  i_wch        in   MST_NB*WCH_W   per-master W payload
//  o_awvalid    out  1              slave AW valid
//  o_awready    in   1              slave AW ready
//  o_awch       out  AWCH_W         slave AW payload
//  o_wvalid     out  1              slave W valid
//  o_wready     in   1              slave W ready
//  o_wlast      out  1              slave W last
//  o_wch        out  WCH_W          slave W payload
//  i_bdone      in   1              slave-side bvalid&bready pulse (one per completed write)
//  o_grant      out  clog2(MST_NB)  index of the current or last AW grant
//  o_ostd_cnt   out  clog2(OSTD_NUM+1)  outstanding write count
// BEHAVIOUR
//  Reset (aresetn low, or srst high at clk edge) clears:
//   - FSM=IDLE; rr_ptr=0; o_grant=0; o_ostd_cnt=0; order queue empty.
//   - All valids and readys = 0.
//   - Reset mid-burst drops in-flight order entries; no W beat is forwarded.
//  AW FSM:
//   - IDLE: the winner is chosen when all of these hold: any i_awvalid, ostd_cnt<OSTD_NUM, queue not full.
//     Round-robin search starts at rr_ptr. Register o_grant=winner; go to GRANT. No handshake in IDLE.
//   - GRANT: o_awvalid=i_awvalid[o_grant]; o_awch=i_awch[o_grant]; i_awready[o_grant]=o_awready; others 0.
//     Grant is held until the handshake. On handshake: push o_grant into the order queue,
//     rr_ptr=o_grant+1 (wraps MST_NB-1 -> 0), ostd_cnt+1, go to IDLE.
//   - Latency is 1 cycle request->o_awvalid; throughput is at most 1 AW per 2 cycles.
//  W routing:
//   - Queue empty: o_wvalid=0, all i_wready=0. There is no bypass, so the first W follows its AW push by >=1 cycle.
//   - Queue non-empty: h=head. o_wvalid/o_wlast/o_wch come from master h; i_wready[h]=o_wready; others 0.
//   - Pop on o_wvalid&o_wready&o_wlast.
//   - Push and pop in the same cycle are legal; occupancy is unchanged.
//  Outstanding counter:
//   - +1 on AW handshake, -1 on i_bdone; both in the same cycle leaves it unchanged.
//   - i_bdone at 0 is ignored (counter stays 0); a simulation assertion fires.
//   - cnt==OSTD_NUM blocks new grants only. A GRANT already in progress completes,
//     since the grant was taken only with cnt<OSTD_NUM.
// CONFIGURATION
//  AXICB_WR_ARB_QOS_EN defined:
//   - Adds input i_awqos (MST_NB*4).
//   - In IDLE, among valid requesters, the highest QoS wins; ties are broken round-robin from rr_ptr.
//  AXICB_WR_ARB_QOS_EN undefined:
//   - Port absent; pure round-robin.
// STRUCTURE
//  Package axicb_pkg:
//   - FSM enum {IDLE, GRANT}.
//   - Width helpers for MST_IDX_W=clog2(MST_NB) and CNT_W=clog2(OSTD_NUM+1).
//  Sub-modules:
//   - axicb_rr_arbiter: combinational pick from req vector + rr_ptr (+ QoS when enabled).
//   - Order queue reuses axicb_scfifo (PASS_THRU=0, DATA_WIDTH=MST_IDX_W, ADDR_WIDTH=clog2(OSTD_NUM)).
// TESTING
//  T1 reset: aresetn low while masters request ->
//     all outputs 0, o_ostd_cnt=0; first o_awvalid 1 cycle after release.
//  T2 fairness: masters 0..3 request AW continuously, o_awready=1, i_bdone every cycle ->
//     grant order 0,1,2,3,0; one AW every 2 cycles.
//  T3 W ordering: AW grants M2 (len 3) then M0 (len 1); both drive W early ->
//     output shows M2 beats x4, wlast, then M0 beats x2; M0 i_wready=0 until M2 wlast.
//  T4 outstanding cap (OSTD_NUM=4): 4 AWs accepted, no i_bdone ->
//     5th request stalls, o_ostd_cnt=4; one i_bdone -> grant 1 cycle later.
//  T5 simultaneous events: AW handshake + i_bdone in the same cycle ->
//     cnt unchanged; queue push + wlast pop in the same cycle -> occupancy unchanged.
//  T6 QoS (macro on): M1 qos=3, M3 qos=7, M0 qos=7, rr_ptr=1 ->
//     M3 granted, then M0, then M1.

Source files
------------

// File: rtl/axicb_pkg.sv
// Shared types and width helpers for the crossbar write-path arbiter.
package axicb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index/count width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axicb_rr_arbiter.sv
// Combinational round-robin pick; highest QoS first when AXICB_WR_ARB_QOS_EN.
module axicb_rr_arbiter
    import axicb_pkg::*;
#(
    parameter int REQ_NB = 4,
    parameter int IDX_W  = idx_w(REQ_NB)
)(
`ifdef AXICB_WR_ARB_QOS_EN
    input  logic [REQ_NB*4-1:0] qos,
`endif
    input  logic [REQ_NB-1:0]   req,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [IDX_W-1:0]    grant,
    output logic                grant_vld
);

    logic [REQ_NB-1:0] elig;
    logic [IDX_W:0]    idx;

`ifdef AXICB_WR_ARB_QOS_EN
    logic [3:0] top_qos;

    // Only requesters at the highest QoS level take part in the rotation.
    always_comb begin
        top_qos = '0;
        elig    = '0;
        for (int m = 0; m < REQ_NB; m++) begin
            if (req[m] && (qos[m*4 +: 4] > top_qos)) top_qos = qos[m*4 +: 4];
        end
        for (int m = 0; m < REQ_NB; m++) begin
            elig[m] = req[m] && (qos[m*4 +: 4] == top_qos);
        end
    end
`else
    assign elig = req;
`endif

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(REQ_NB)) idx = idx - (IDX_W+1)'(REQ_NB);
            if (!grant_vld && elig[idx[IDX_W-1:0]]) begin
                grant     = idx[IDX_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO with optional empty-path bypass (PASS_THRU).
module axicb_scfifo #(
    parameter int PASS_THRU  = 0,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
)(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  pop,
    output logic                  empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  empty_q;
    logic                  bypass;
    logic                  wr_en;
    logic                  rd_en;

    assign empty_q = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    generate
        if (PASS_THRU != 0) begin : g_pass
            assign bypass   = empty_q && push && pop;
            assign empty    = empty_q && !push;
            assign data_out = empty_q ? data_in : mem[rd_ptr[ADDR_WIDTH-1:0]];
        end else begin : g_reg
            assign bypass   = 1'b0;
            assign empty    = empty_q;
            assign data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    endgenerate

    assign wr_en = push && !full && !bypass;
    assign rd_en = pop && !empty_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end

endmodule

// File: rtl/axicb_wr_arbiter.sv
// Write-path arbiter for one crossbar slave port: RR AW grant, W in grant order.
// Optional QoS-aware AW pick via AXICB_WR_ARB_QOS_EN.
module axicb_wr_arbiter
    import axicb_pkg::*;
#(
    parameter int MST_NB   = 4,
    parameter int AWCH_W   = 8,
    parameter int WCH_W    = 8,
    parameter int OSTD_NUM = 4
)(
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          srst,
`ifdef AXICB_WR_ARB_QOS_EN
    input  logic [MST_NB*4-1:0]           i_awqos,
`endif
    input  logic [MST_NB-1:0]             i_awvalid,
    output logic [MST_NB-1:0]             i_awready,
    input  logic [MST_NB*AWCH_W-1:0]      i_awch,
    input  logic [MST_NB-1:0]             i_wvalid,
    output logic [MST_NB-1:0]             i_wready,
    input  logic [MST_NB-1:0]             i_wlast,
    input  logic [MST_NB*WCH_W-1:0]       i_wch,
    output logic                          o_awvalid,
    input  logic                          o_awready,
    output logic [AWCH_W-1:0]             o_awch,
    output logic                          o_wvalid,
    input  logic                          o_wready,
    output logic                          o_wlast,
    output logic [WCH_W-1:0]              o_wch,
    input  logic                          i_bdone,
    output logic [idx_w(MST_NB)-1:0]      o_grant,
    output logic [idx_w(OSTD_NUM+1)-1:0]  o_ostd_cnt
);

    localparam int MST_IDX_W = idx_w(MST_NB);
    localparam int CNT_W     = idx_w(OSTD_NUM + 1);
    localparam int QA_W      = idx_w(OSTD_NUM);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [MST_IDX_W-1:0]   rr_ptr;
    logic [MST_IDX_W-1:0]   rr_nxt;
    logic [MST_IDX_W-1:0]   grant_nxt;
    logic [MST_IDX_W-1:0]   pick;
    logic                   pick_vld;
    logic                   can_grant;
    logic                   aw_hs;
    logic                   w_pop;
    logic                   q_full;
    logic                   q_empty;
    logic [MST_IDX_W-1:0]   q_head;
    logic                   cnt_dec;

    axicb_rr_arbiter #(
        .REQ_NB (MST_NB)
    ) u_rr (
`ifdef AXICB_WR_ARB_QOS_EN
        .qos       (i_awqos),
`endif
        .req       (i_awvalid),
        .rr_ptr    (rr_ptr),
        .grant     (pick),
        .grant_vld (pick_vld)
    );

    // Holds the master index of every accepted AW until its last W beat leaves.
    axicb_scfifo #(
        .PASS_THRU  (0),
        .DATA_WIDTH (MST_IDX_W),
        .ADDR_WIDTH (QA_W)
    ) u_order_q (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .data_in  (o_grant),
        .push     (aw_hs),
        .full     (q_full),
        .data_out (q_head),
        .pop      (w_pop),
        .empty    (q_empty)
    );

    assign can_grant = (o_ostd_cnt < CNT_W'(OSTD_NUM)) && !q_full;
    assign cnt_dec   = i_bdone && (o_ostd_cnt != '0);

    always_comb begin
        state_nxt = state;
        grant_nxt = o_grant;
        rr_nxt    = rr_ptr;
        aw_hs     = 1'b0;
        o_awvalid = 1'b0;
        o_awch    = '0;
        i_awready = '0;
        unique case (state)
            IDLE: begin
                if (pick_vld && can_grant) begin
                    grant_nxt = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                o_awvalid          = i_awvalid[o_grant];
                o_awch             = i_awch[int'(o_grant)*AWCH_W +: AWCH_W];
                i_awready[o_grant] = o_awready;
                if (o_awvalid && o_awready) begin
                    aw_hs     = 1'b1;
                    rr_nxt    = (o_grant == MST_IDX_W'(MST_NB - 1)) ?
                                '0 : o_grant + 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        o_wvalid = 1'b0;
        o_wlast  = 1'b0;
        o_wch    = '0;
        i_wready = '0;
        if (!q_empty) begin
            o_wvalid         = i_wvalid[q_head];
            o_wlast          = i_wlast[q_head];
            o_wch            = i_wch[int'(q_head)*WCH_W +: WCH_W];
            i_wready[q_head] = o_wready;
        end
    end

    assign w_pop = o_wvalid && o_wready && o_wlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            o_grant    <= '0;
            o_ostd_cnt <= '0;
        end else if (srst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            o_grant    <= '0;
            o_ostd_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_nxt;
            o_grant <= grant_nxt;
            unique case ({aw_hs, cnt_dec})
                2'b10:   o_ostd_cnt <= o_ostd_cnt + 1'b1;
                2'b01:   o_ostd_cnt <= o_ostd_cnt - 1'b1;
                default: o_ostd_cnt <= o_ostd_cnt;
            endcase
        end
    end

`ifndef SYNTHESIS
    bdone_underflow: assert property (@(posedge aclk)
        disable iff (!aresetn || srst) !(i_bdone && o_ostd_cnt == '0));
`endif

endmodule

// File: tb/tb_axicb_wr_arbiter.sv
// Directed bench for axicb_wr_arbiter: vector table plus multi-cycle sequences.
module tb_axicb_wr_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        srst = 1'b0;
    logic [3:0]  i_awvalid, i_awready, i_wvalid, i_wready, i_wlast;
    logic [31:0] i_awch, i_wch;
    logic        o_awvalid, o_awready, o_wvalid, o_wready, o_wlast, i_bdone;
    logic [7:0]  o_awch, o_wch;
    logic [1:0]  o_grant;
    logic [2:0]  o_ostd_cnt;
    logic [7:0]  wch_m [4];
`ifdef AXICB_WR_ARB_QOS_EN
    logic [15:0] i_awqos;
`endif

    assign i_awch = 32'hA3A2A1A0;
    assign i_wch  = {wch_m[3], wch_m[2], wch_m[1], wch_m[0]};

    axicb_wr_arbiter #(
        .MST_NB (4), .AWCH_W (8), .WCH_W (8), .OSTD_NUM (4)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .srst       (srst),
`ifdef AXICB_WR_ARB_QOS_EN
        .i_awqos    (i_awqos),
`endif
        .i_awvalid  (i_awvalid),
        .i_awready  (i_awready),
        .i_awch     (i_awch),
        .i_wvalid   (i_wvalid),
        .i_wready   (i_wready),
        .i_wlast    (i_wlast),
        .i_wch      (i_wch),
        .o_awvalid  (o_awvalid),
        .o_awready  (o_awready),
        .o_awch     (o_awch),
        .o_wvalid   (o_wvalid),
        .o_wready   (o_wready),
        .o_wlast    (o_wlast),
        .o_wch      (o_wch),
        .i_bdone    (i_bdone),
        .o_grant    (o_grant),
        .o_ostd_cnt (o_ostd_cnt)
    );

    initial forever #5 aclk = ~aclk;

    typedef struct packed {
        logic       srst;
        logic [3:0] awv;
        logic       awr;
        logic [3:0] wv;
        logic [3:0] wl;
        logic       wr;
        logic       bd;
        logic       e_awv;
        logic [1:0] e_grant;
        logic [2:0] e_cnt;
        logic [3:0] e_awr;
        logic       e_wv;
        logic       e_wl;
        logic [3:0] e_wr;
        logic [1:0] e_wm;
    } vec_t;

    vec_t       vecs [18];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] pend;
    int         gq[$];
    int         cq[$];
    int         maxcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        srst      = 1'b0;
        i_awvalid = '0;
        o_awready = 1'b0;
        i_wvalid  = '0;
        i_wlast   = '0;
        o_wready  = 1'b0;
        i_bdone   = 1'b0;
        for (int m = 0; m < 4; m++) wch_m[m] = 8'hD0 + 8'(m);
`ifdef AXICB_WR_ARB_QOS_EN
        i_awqos = '0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    // Every master keeps W valid+last so the order queue drains; B returns while count is non-zero.
    task automatic run_aw(input int ncyc, input bit keep);
        for (int c = 0; c < ncyc; c++) begin
            i_awvalid = pend;
            o_awready = 1'b1;
            i_wvalid  = 4'hF;
            i_wlast   = 4'hF;
            o_wready  = 1'b1;
            i_bdone   = (o_ostd_cnt != 3'd0);
            #1;
            if (int'(o_ostd_cnt) > maxcnt) maxcnt = int'(o_ostd_cnt);
            if (o_awvalid && o_awready) begin
                gq.push_back(int'(o_grant));
                cq.push_back(c);
                if (!keep) pend[o_grant] = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            srst awv     awr  wv      wl      wr   bd   eawv egr  ecnt eawr    ewv  ewl  ewr     ewm
        vecs[0]  = '{1'b0,4'b0000,1'b0,4'b0000,4'b0000,1'b0,1'b0,1'b0,2'd0,3'd0,4'b0000,1'b0,1'b0,4'b0000,2'd0};
        vecs[1]  = '{1'b0,4'b0010,1'b1,4'b0000,4'b0000,1'b0,1'b0,1'b0,2'd0,3'd0,4'b0000,1'b0,1'b0,4'b0000,2'd0};
        vecs[2]  = '{1'b0,4'b0010,1'b1,4'b0000,4'b0000,1'b0,1'b0,1'b1,2'd1,3'd0,4'b0010,1'b0,1'b0,4'b0000,2'd0};
        vecs[3]  = '{1'b0,4'b0000,1'b0,4'b0010,4'b0010,1'b0,1'b0,1'b0,2'd1,3'd1,4'b0000,1'b1,1'b1,4'b0000,2'd1};
        vecs[4]  = '{1'b0,4'b0000,1'b0,4'b0010,4'b0010,1'b1,1'b0,1'b0,2'd1,3'd1,4'b0000,1'b1,1'b1,4'b0010,2'd1};
        vecs[5]  = '{1'b0,4'b0000,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0,2'd1,3'd1,4'b0000,1'b0,1'b0,4'b0000,2'd0};
        vecs[6]  = '{1'b0,4'b1001,1'b1,4'b0000,4'b0000,1'b0,1'b0,1'b0,2'd1,3'd0,4'b0000,1'b0,1'b0,4'b0000,2'd0};
        vecs[7]  = '{1'b0,4'b1001,1'b0,4'b0000,4'b0000,1'b0,1'b0,1'b1,2'd3,3'd0,4'b0000,1'b0,1'b0,4'b0000,2'd0};
        vecs[8]  = '{1'b0,4'b1001,1'b1,4'b0000,4'b0000,1'b0,1'b0,1'b1,2'd3,3'd0,4'b1000,1'b0,1'b0,4'b0000,2'd0};
        vecs[9]  = '{1'b0,4'b1001,1'b1,4'b0000,4'b0000,1'b1,1'b1,1'b0,2'd3,3'd1,4'b0000,1'b0,1'b0,4'b1000,2'd3};
        vecs[10] = '{1'b0,4'b1001,1'b1,4'b1001,4'b1000,1'b1,1'b0,1'b1,2'd0,3'd0,4'b0001,1'b1,1'b1,4'b1000,2'd3};
        vecs[11] = '{1'b0,4'b0000,1'b0,4'b0001,4'b0000,1'b1,1'b0,1'b0,2'd0,3'd1,4'b0000,1'b1,1'b0,4'b0001,2'd0};
        vecs[12] = '{1'b0,4'b0000,1'b0,4'b0001,4'b0001,1'b1,1'b0,1'b0,2'd0,3'd1,4'b0000,1'b1,1'b1,4'b0001,2'd0};
        vecs[13] = '{1'b0,4'b0000,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0,2'd0,3'd1,4'b0000,1'b0,1'b0,4'b0000,2'd0};
        vecs[14] = '{1'b0,4'b0100,1'b1,4'b0000,4'b0000,1'b0,1'b0,1'b0,2'd0,3'd0,4'b0000,1'b0,1'b0,4'b0000,2'd0};
        vecs[15] = '{1'b1,4'b0100,1'b1,4'b0000,4'b0000,1'b0,1'b0,1'b1,2'd2,3'd0,4'b0100,1'b0,1'b0,4'b0000,2'd0};
        vecs[16] = '{1'b0,4'b0100,1'b1,4'b0000,4'b0000,1'b0,1'b0,1'b0,2'd0,3'd0,4'b0000,1'b0,1'b0,4'b0000,2'd0};
        vecs[17] = '{1'b0,4'b0000,1'b0,4'b0000,4'b0000,1'b0,1'b0,1'b0,2'd2,3'd0,4'b0000,1'b0,1'b0,4'b0000,2'd0};

        // T1: async reset while every master requests
        idle_inputs();
        aresetn   = 1'b0;
        i_awvalid = 4'hF;
        o_awready = 1'b1;
        i_wvalid  = 4'hF;
        i_wlast   = 4'hF;
        o_wready  = 1'b1;
        tick();
        tick();
        chk("t1_rst_awvalid", o_awvalid, 0);
        chk("t1_rst_awready", i_awready, 0);
        chk("t1_rst_wvalid", o_wvalid, 0);
        chk("t1_rst_wready", i_wready, 0);
        chk("t1_rst_wlast", o_wlast, 0);
        chk("t1_rst_grant", o_grant, 0);
        chk("t1_rst_cnt", o_ostd_cnt, 0);
        aresetn = 1'b1;
        #1;
        chk("t1_rel_awvalid", o_awvalid, 0);
        tick();
        chk("t1_first_awvalid", o_awvalid, 1);
        chk("t1_first_grant", o_grant, 0);

        // Vector table
        do_reset();
        for (int k = 0; k < 18; k++) begin
            srst      = vecs[k].srst;
            i_awvalid = vecs[k].awv;
            o_awready = vecs[k].awr;
            i_wvalid  = vecs[k].wv;
            i_wlast   = vecs[k].wl;
            o_wready  = vecs[k].wr;
            i_bdone   = vecs[k].bd;
            #1;
            chk($sformatf("v%0d_awvalid", k), o_awvalid, vecs[k].e_awv);
            chk($sformatf("v%0d_grant", k), o_grant, vecs[k].e_grant);
            chk($sformatf("v%0d_cnt", k), o_ostd_cnt, vecs[k].e_cnt);
            chk($sformatf("v%0d_awready", k), i_awready, vecs[k].e_awr);
            chk($sformatf("v%0d_wvalid", k), o_wvalid, vecs[k].e_wv);
            chk($sformatf("v%0d_wlast", k), o_wlast, vecs[k].e_wl);
            chk($sformatf("v%0d_wready", k), i_wready, vecs[k].e_wr);
            if (vecs[k].e_awv)
                chk($sformatf("v%0d_awch", k), o_awch, 8'hA0 + 8'(vecs[k].e_grant));
            if (vecs[k].e_wv)
                chk($sformatf("v%0d_wch", k), o_wch, 8'hD0 + 8'(vecs[k].e_wm));
            tick();
        end

        // T2: fairness, continuous requests
        do_reset();
        pend = 4'hF;
        gq.delete();
        cq.delete();
        maxcnt = 0;
        run_aw(10, 1'b1);
        chk("t2_count", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) begin
            chk($sformatf("t2_grant%0d", i), gq[i], i % 4);
            chk($sformatf("t2_cycle%0d", i), cq[i], 2 * i + 1);
        end
        chk("t2_maxcnt", maxcnt, 1);

        // T3: W routed in AW grant order
        do_reset();
        begin
            int         beat [4];
            int         len [4];
            bit         m2_done;
            bit         awdone2;
            int         early;
            logic [3:0] wh;
            logic [8:0] got[$];
            logic [8:0] exp_w [6];
            exp_w   = '{9'h020, 9'h021, 9'h022, 9'h123, 9'h000, 9'h101};
            beat    = '{0, 0, 0, 0};
            len     = '{1, 0, 3, 0};
            m2_done = 1'b0;
            early   = 0;
            pend    = 4'b0100;
            for (int c = 0; c < 30 && got.size() < 6; c++) begin
                i_awvalid = pend;
                o_awready = 1'b1;
                o_wready  = 1'b1;
                i_bdone   = 1'b0;
                for (int m = 0; m < 4; m++) begin
                    i_wvalid[m] = (m == 0 || m == 2) && (beat[m] <= len[m]);
                    i_wlast[m]  = (beat[m] == len[m]);
                    wch_m[m]    = 8'((m << 4) | beat[m]);
                end
                #1;
                if (i_wready[0] && !m2_done) early++;
                if (o_wvalid && o_wready) begin
                    got.push_back({o_wlast, o_wch});
                    if (o_wlast && o_wch[7:4] == 4'h2) m2_done = 1'b1;
                end
                wh      = i_wvalid & i_wready;
                awdone2 = o_awvalid && o_awready && (o_grant == 2'd2);
                if (o_awvalid && o_awready) pend[o_grant] = 1'b0;
                tick();
                for (int m = 0; m < 4; m++) if (wh[m]) beat[m]++;
                if (awdone2) pend[0] = 1'b1;
            end
            chk("t3_count", got.size(), 6);
            for (int i = 0; i < 6 && i < got.size(); i++)
                chk($sformatf("t3_beat%0d", i), got[i], exp_w[i]);
            chk("t3_m0_early_wready", early, 0);
        end

        // T4: outstanding cap
        do_reset();
        begin
            int hs = 0;
            for (int c = 0; c < 12; c++) begin
                i_awvalid = 4'b0010;
                o_awready = 1'b1;
                i_wvalid  = 4'b0010;
                i_wlast   = 4'b0010;
                o_wready  = 1'b1;
                #1;
                if (o_awvalid && o_awready) hs++;
                tick();
            end
            chk("t4_accepted", hs, 4);
        end
        chk("t4_cnt_full", o_ostd_cnt, 4);
        chk("t4_stalled", o_awvalid, 0);
        i_bdone = 1'b1;
        #1;
        chk("t4_bdone_awvalid", o_awvalid, 0);
        tick();
        i_bdone = 1'b0;
        #1;
        chk("t4_cnt_after_b", o_ostd_cnt, 3);
        chk("t4_idle_awvalid", o_awvalid, 0);
        tick();
        chk("t4_regrant_awvalid", o_awvalid, 1);
        chk("t4_regrant_grant", o_grant, 1);
        chk("t4_regrant_awready", i_awready, 4'b0010);
        tick();
        chk("t4_cnt_refull", o_ostd_cnt, 4);

        // T5: same-cycle AW+B and push+pop
        do_reset();
        i_awvalid = 4'b0001;
        o_awready = 1'b1;
        tick();
        #1;
        chk("t5_hs0", o_awvalid, 1);
        tick();
        i_awvalid = 4'b0010;
        #1;
        chk("t5_cnt1", o_ostd_cnt, 1);
        chk("t5_head0_idle", o_wvalid, 0);
        tick();
        i_bdone  = 1'b1;
        i_wvalid = 4'b0001;
        i_wlast  = 4'b0001;
        o_wready = 1'b1;
        #1;
        chk("t5_hs1", o_awvalid, 1);
        chk("t5_pop0_wready", i_wready, 4'b0001);
        tick();
        i_awvalid = 4'b0000;
        i_bdone   = 1'b0;
        i_wvalid  = 4'b0010;
        i_wlast   = 4'b0000;
        #1;
        chk("t5_cnt_same", o_ostd_cnt, 1);
        chk("t5_head1_wvalid", o_wvalid, 1);
        chk("t5_head1_wready", i_wready, 4'b0010);
        chk("t5_head1_wch", o_wch, 8'hD1);
        tick();
        i_wlast = 4'b0010;
        #1;
        chk("t5_head1_wlast", o_wlast, 1);
        tick();
        i_wvalid = 4'b0011;
        i_wlast  = 4'b0011;
        i_bdone  = 1'b1;
        #1;
        chk("t5_empty_wvalid", o_wvalid, 0);
        chk("t5_empty_wready", i_wready, 0);
        tick();
        i_bdone = 1'b0;
        #1;
        chk("t5_cnt_zero", o_ostd_cnt, 0);

`ifdef AXICB_WR_ARB_QOS_EN
        // T6: QoS pick with rr_ptr=1
        do_reset();
        gq.delete();
        cq.delete();
        maxcnt = 0;
        pend = 4'b0001;
        run_aw(2, 1'b0);
        chk("t6_setup", gq.size(), 1);
        gq.delete();
        i_awqos = {4'd7, 4'd0, 4'd3, 4'd7};
        pend = 4'b1011;
        run_aw(8, 1'b0);
        chk("t6_count", gq.size(), 3);
        if (gq.size() == 3) begin
            chk("t6_first", gq[0], 3);
            chk("t6_second", gq[1], 0);
            chk("t6_third", gq[2], 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
